// File: rtl/fixed_point_defs.sv
// Shared fixed-point constants and control-state encoding for the squarer and
// the square-root unit that sits beside it in the arithmetic execution stage.
package fixed_point_defs;

  localparam int WIDTH = 32;
  localparam int SCALE = 17;
  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [WIDTH-1:0] FP_ONE     = WIDTH'(1) << SCALE;
  localparam logic [WIDTH-1:0] FP_SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fixed_square_datapath.sv
// Radix-2 shift-add multiplier core for the squarer: squares an unsigned
// magnitude one multiplier bit per step. Sequencing comes from the parent FSM.
module fixed_square_datapath
  import fixed_point_defs::*;
#(
  parameter int W = WIDTH
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           step,
  input  logic [W-1:0]   magnitude,
  output logic [2*W-1:0] product
);

  logic [2*W-1:0] multiplicand_p0;
  logic [W-1:0]   multiplier_p0;
  logic [2*W-1:0] acc_p0;

  // Load operands on accept, then one conditional add and shift per step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      multiplicand_p0 <= '0;
      multiplier_p0   <= '0;
      acc_p0          <= '0;
    end else if (load) begin
      multiplicand_p0 <= {{W{1'b0}}, magnitude};
      multiplier_p0   <= magnitude;
      acc_p0          <= '0;
    end else if (step) begin
      if (multiplier_p0[0]) begin
        acc_p0 <= acc_p0 + multiplicand_p0;
      end
      multiplicand_p0 <= multiplicand_p0 << 1;
      multiplier_p0   <= multiplier_p0 >> 1;
    end
  end

  assign product = acc_p0;

endmodule

// File: rtl/fixed_point_square.sv
// Multi-cycle signed fixed-point squarer (Q(WIDTH-SCALE).SCALE in and out).
// Fixed latency of WIDTH shift-add steps; results above the positive range
// saturate. Build option: FIXED_SQUARE_ROUND_EN selects round-half-up instead
// of truncation when dropping the SCALE fractional bits.
module fixed_point_square
  import fixed_point_defs::*;
(
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic signed [WIDTH-1:0] iOperand,
  input  logic                    iInputReady,
  output logic                    oBusy,
  output logic                    oOutputReady,
  output logic        [WIDTH-1:0] oResult,
  output logic                    oOverflow
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
`ifdef FIXED_SQUARE_ROUND_EN
  localparam logic [2*WIDTH:0] ROUND_HALF = (2*WIDTH+1)'(1) << (SCALE - 1);
`endif

  // Drop the fraction bits of the full product and clamp to the positive max.
  // Returns {overflow, result}; the extra top bit absorbs the rounding carry.
  function automatic logic [WIDTH:0] scale_sat(input logic [2*WIDTH-1:0] p);
    logic [2*WIDTH:0] sum;
    logic [2*WIDTH:0] r;
`ifdef FIXED_SQUARE_ROUND_EN
    sum = {1'b0, p} + ROUND_HALF;
`else
    sum = {1'b0, p};
`endif
    r = sum >> SCALE;
    if (|r[2*WIDTH:WIDTH-1]) begin
      scale_sat = {1'b1, FP_SAT_MAX};
    end else begin
      scale_sat = {1'b0, r[WIDTH-1:0]};
    end
  endfunction

  state_t             state;
  state_t             state_next;
  logic               load;
  logic               step;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   magnitude;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH:0]     scaled;

  // The most negative operand maps to 2^(WIDTH-1), representable as unsigned
  assign magnitude = iOperand[WIDTH-1] ? $unsigned(-iOperand) : $unsigned(iOperand);
  assign oBusy     = (state != IDLE);
  assign scaled    = scale_sat(product);

  fixed_square_datapath #(
    .W(WIDTH)
  ) u_datapath (
    .clk      (Clock),
    .rst_n    (Reset),
    .load     (load),
    .step     (step),
    .magnitude(magnitude),
    .product  (product)
  );

  // State register
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and datapath controls; requests outside IDLE are ignored
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE: begin
        if (iInputReady) begin
          load       = 1'b1;
          state_next = CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (cnt == LAST_STEP) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Step counter: cleared on accept, advanced once per shift-add step
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (step) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Result registers update only when leaving DONE; ready pulses for one cycle
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      oOutputReady <= 1'b0;
      oResult      <= '0;
      oOverflow    <= 1'b0;
    end else begin
      oOutputReady <= (state == DONE);
      if (state == DONE) begin
        {oOverflow, oResult} <= scaled;
      end
    end
  end

endmodule

// File: tb/tb_fixed_point_square.sv
// Self-checking bench for fixed_point_square: directed corner cases, a
// mid-operation reset, random operands and back-to-back requests, all checked
// against an arithmetic reference of the squaring/scaling rules.
module tb_fixed_point_square;

  logic               Clock;
  logic               Reset;
  logic signed [31:0] iOperand;
  logic               iInputReady;
  logic               oBusy;
  logic               oOutputReady;
  logic        [31:0] oResult;
  logic               oOverflow;

  int checks = 0;
  int errors = 0;

  fixed_point_square dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .iOperand    (iOperand),
    .iInputReady (iInputReady),
    .oBusy       (oBusy),
    .oOutputReady(oOutputReady),
    .oResult     (oResult),
    .oOverflow   (oOverflow)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Reference: exact square of the signed value, drop 17 fraction bits, clamp
  function automatic logic [32:0] ref_square(input logic [31:0] x);
    longint signed v;
    logic [63:0]   p;
    logic [64:0]   r;
    v = longint'($signed(x));
    p = 64'(v * v);
`ifdef FIXED_SQUARE_ROUND_EN
    r = ({1'b0, p} + (65'd1 << 16)) >> 17;
`else
    r = {1'b0, p} >> 17;
`endif
    if (r >= (65'd1 << 31)) return {1'b1, 32'h7FFFFFFF};
    return {1'b0, r[31:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request, measure latency to the ready pulse and check the result
  task automatic run_op(input logic [31:0] x, input string tag,
                        output logic [31:0] res, output logic ovf);
    int          edges;
    logic [32:0] exp;
    @(negedge Clock);
    iOperand    = x;
    iInputReady = 1'b1;
    @(posedge Clock);
    #1;
    iInputReady = 1'b0;
    check({tag, " busy"}, oBusy, 1'b1);
    edges = 0;
    while (!oOutputReady && edges < 100) begin
      @(posedge Clock);
      #1;
      edges++;
    end
    check({tag, " latency"}, edges, 33);
    exp = ref_square(x);
    check({tag, " result"}, oResult, exp[31:0]);
    check({tag, " overflow"}, oOverflow, exp[32]);
    res = oResult;
    ovf = oOverflow;
  endtask

  initial begin
    logic [31:0] res;
    logic        ovf;
    logic [31:0] x;
    logic [31:0] cur;
    logic [31:0] last_res;
    logic [32:0] exp;
    logic [32:0] q[$];
    logic        pulse_exp;
    int          cd;
    int          pulses;

    Reset       = 1'b0;
    iOperand    = '0;
    iInputReady = 1'b0;

    // Reset state
    #1;
    check("reset busy", oBusy, 1'b0);
    check("reset ready", oOutputReady, 1'b0);
    check("reset result", oResult, 32'h0);
    check("reset overflow", oOverflow, 1'b0);
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b1;

    // Directed values
    run_op(32'h0004_0000, "two", res, ovf);
    check("two const", {ovf, res}, {1'b0, 32'h0008_0000});
    run_op(32'hFFFA_0000, "minus_three", res, ovf);
    check("minus_three const", {ovf, res}, {1'b0, 32'h0012_0000});
    run_op(32'h0001_0000, "half", res, ovf);
    check("half const", {ovf, res}, {1'b0, 32'h0000_8000});
    run_op(32'h0000_0000, "zero", res, ovf);
    check("zero const", {ovf, res}, {1'b0, 32'h0});
    run_op(32'h0100_0000, "big", res, ovf);
    check("big const", {ovf, res}, {1'b1, 32'h7FFF_FFFF});
    run_op(32'h8000_0000, "most_neg", res, ovf);
    check("most_neg const", {ovf, res}, {1'b1, 32'h7FFF_FFFF});
    run_op(32'h0000_0100, "round_edge", res, ovf);
`ifdef FIXED_SQUARE_ROUND_EN
    check("round_edge const", {ovf, res}, {1'b0, 32'h1});
`else
    check("round_edge const", {ovf, res}, {1'b0, 32'h0});
`endif
    run_op(32'h0000_0001, "lsb", res, ovf);
    check("lsb const", {ovf, res}, {1'b0, 32'h0});
    run_op(32'h0004_0000, "two_again", res, ovf);

    // Reset after 10 steps of a calculation
    @(negedge Clock);
    iOperand    = 32'h0003_0000;
    iInputReady = 1'b1;
    @(posedge Clock);
    #1;
    iInputReady = 1'b0;
    repeat (10) @(posedge Clock);
    #1;
    Reset = 1'b0;
    #1;
    check("midreset busy", oBusy, 1'b0);
    check("midreset ready", oOutputReady, 1'b0);
    check("midreset result", oResult, 32'h0);
    check("midreset overflow", oOverflow, 1'b0);
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    Reset  = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(posedge Clock);
      #1;
      if (oOutputReady) pulses++;
    end
    check("midreset no pulse", pulses, 0);
    run_op(32'hFFFA_0000, "after_reset", res, ovf);

    // Random operands, half of them scaled down to stay in range
    for (int i = 0; i < 16; i++) begin
      x = $urandom;
      if (i % 2 == 1) x = 32'($signed(x) >>> $urandom_range(8, 24));
      run_op(x, "random", res, ovf);
    end

    // Request held high with a new operand every cycle
    last_res = res;
    cd       = 0;
    for (int i = 0; i < 5 * 34 + 2; i++) begin
      @(negedge Clock);
      cur         = $urandom >> $urandom_range(0, 20);
      iOperand    = cur;
      iInputReady = 1'b1;
      @(posedge Clock);
      #1;
      pulse_exp = 1'b0;
      if (cd == 0) begin
        q.push_back(ref_square(cur));
        cd = 33;
      end else begin
        cd--;
        if (cd == 0) pulse_exp = 1'b1;
      end
      check("stream pulse", oOutputReady, pulse_exp);
      if (pulse_exp && q.size() > 0) begin
        exp = q.pop_front();
        check("stream result", {oOverflow, oResult}, exp);
        last_res = exp[31:0];
      end else begin
        check("stream hold", oResult, last_res);
      end
    end
    @(negedge Clock);
    iInputReady = 1'b0;
    repeat (40) @(posedge Clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
